// File: rtl/dr_pkg.sv
// Shared types and dual-rail helpers for the NCL source block.
package dr_pkg;

    localparam int unsigned RAIL_NUM = 2;
    localparam int unsigned RAIL_F   = 0;
    localparam int unsigned RAIL_T   = 1;

    // Widest word the helpers handle; callers zero-extend and truncate.
    localparam int unsigned DR_MAX_W = 64;

    typedef enum logic {
        S_NULL,
        S_DATA
    } dr_state_e;

    // Bit i set -> true rail high, bit i clear -> false rail high.
    function automatic logic [RAIL_NUM*DR_MAX_W-1:0] dr_encode(input logic [DR_MAX_W-1:0] word);
        logic [RAIL_NUM*DR_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < DR_MAX_W; i++) begin
            v[RAIL_NUM*i + RAIL_T] = word[i];
            v[RAIL_NUM*i + RAIL_F] = ~word[i];
        end
        return v;
    endfunction

    function automatic logic dr_is_null(input logic [RAIL_NUM*DR_MAX_W-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-high reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dr_src.sv
// Clocked dual-rail NCL source: turns valid/ready words into four-phase DATA/NULL
// wavefronts paced by the downstream request line en.
// Optional stall watchdog: define DR_SRC_TIMEOUT_EN.
module dr_src
    import dr_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      en,
    output logic [WIDTH*RAIL_NUM-1:0] out,
    output logic [CNT_W-1:0]          tok_cnt,
    output logic                      err
);

    localparam int unsigned OUT_W = RAIL_NUM * WIDTH;

    if (WIDTH > DR_MAX_W || SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 2)
    begin : g_param_chk
        $error("dr_src: illegal parameter combination");
    end

    dr_state_e         state_q;
    logic [OUT_W-1:0]  out_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  data_enc;
    logic              en_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_en_sync (
        .clk (clk),
        .rst (rst),
        .d   (en),
        .q   (en_s)
    );

    assign data_enc = OUT_W'(dr_encode(DR_MAX_W'(in_data)));

    // Only flops feed in_ready, so it is stable for the whole cycle.
    assign in_ready = (state_q == S_NULL) && en_s;

    // Four-phase sequencer; every output rail comes straight from out_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NULL;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_NULL: begin
                    if (in_valid && in_ready) begin
                        out_q   <= data_enc;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!en_s) begin
                        out_q   <= '0;
                        state_q <= S_NULL;
                    end
                end
                default: begin
                    out_q   <= '0;
                    state_q <= S_NULL;
                end
            endcase
        end
    end

    assign out     = out_q;
    assign tok_cnt = cnt_q;

`ifdef DR_SRC_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            state_chg;
    logic            wd_run;

    assign state_chg = (state_q == S_NULL && in_valid && in_ready) ||
                       (state_q == S_DATA && !en_s);
    // Waiting on downstream to ask for NULL, or on en while a word is pending.
    assign wd_run    = (state_q == S_DATA && en_s) ||
                       (state_q == S_NULL && !en_s && in_valid);

    // Stall watchdog with sticky error flag; never touches the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_chg) begin
                wd_q <= '0;
            end else if (wd_run && wd_q != WD_W'(TIMEOUT)) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (!state_chg && wd_run && wd_q == WD_W'(TIMEOUT - 1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_src.sv
// Directed bench for dr_src with a scoreboard of expected DATA wavefronts.
module tb_dr_src;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int CNT_W = 16;
    localparam int TMO   = 16;

`ifdef DR_SRC_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              en;
    logic [2*WIDTH-1:0] dout;
    logic [CNT_W-1:0]  tok_cnt;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_tok     = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    dr_src #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .en       (en),
        .out      (dout),
        .tok_cnt  (tok_cnt),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [7:0] w);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v[2*i+1] = w[i];
            v[2*i]   = ~w[i];
        end
        return v;
    endfunction

    function automatic logic rails_ok(input logic [15:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[2*i] && v[2*i+1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: got %h expected <empty scoreboard>", tag, dout);
        end else begin
            e = exp_q.pop_front();
            chk(tag, dout, e);
        end
    endtask

    // Cycles until out goes NULL; 0 means the bound expired.
    task automatic wait_null(output int n);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (dout == '0) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (in_ready) begin
                n = c;
                break;
            end
        end
    endtask

    // Present a word and hold it until it is accepted (bounded).
    task automatic send(input logic [7:0] w, input string tag);
        logic rdy;
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back(enc(w));
        for (int c = 0; c < 20; c++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk({tag, "_accepted"}, 16'(done), 16'd1);
        if (done) exp_tok++;
        pop_chk(tag);
        chk({tag, "_rails"}, 16'(rails_ok(dout)), 16'd1);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out", dout, 16'h0000);
        chk("rst_tok", tok_cnt, 16'd0);
        chk("rst_ready", 16'(in_ready), 16'd0);
        chk("rst_err", 16'(err), 16'd0);

        wait_ready(n);
        chk("rfd_lat_init", 16'(n), 16'(SYNC));

        // First token: fixed encoding of 8'hA5.
        send(8'hA5, "data_a5");
        chk("a5_literal", dout, 16'b10_01_10_01_01_10_01_10);
        chk("a5_tok", tok_cnt, 16'(exp_tok));
        chk("a5_ready", 16'(in_ready), 16'd0);

        // Next word pending while en stays high: DATA held, no second accept.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int c = 0; c < 8; c++) tick();
        chk("hold_out", dout, 16'h9966);
        chk("hold_tok", tok_cnt, 16'd1);
        chk("hold_ready", 16'(in_ready), 16'd0);

        in_valid = 1'b0;
        en = 1'b0;
        wait_null(n);
        chk("rfn_lat", 16'(n), 16'(SYNC + 1));

        // Request-for-null persists: pending word must wait.
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("stall_out", dout, 16'h0000);
        chk("stall_tok", tok_cnt, 16'd1);
        chk("stall_ready", 16'(in_ready), 16'd0);

        en = 1'b1;
        wait_ready(n);
        chk("rfd_lat", 16'(n), 16'(SYNC));
        send(8'h3C, "data_3c");
        chk("3c_tok", tok_cnt, 16'(exp_tok));
        en = 1'b0;
        wait_null(n);
        chk("rfn_lat_2", 16'(n), 16'(SYNC + 1));
        en = 1'b1;
        wait_ready(n);
        chk("rfd_lat_2", 16'(n), 16'(SYNC));

        // in_data wiggling with in_valid low is ignored.
        for (int c = 0; c < 4; c++) begin
            in_data = 8'($urandom);
            tick();
        end
        chk("idle_out", dout, 16'h0000);
        chk("idle_tok", tok_cnt, 16'(exp_tok));

        // A few arbitrary tokens through the full four-phase cycle.
        for (int k = 0; k < 4; k++) begin
            send(8'($urandom), "rand");
            chk("rand_tok", tok_cnt, 16'(exp_tok));
            en = 1'b0;
            wait_null(n);
            chk("rand_rfn", 16'(n), 16'(SYNC + 1));
            en = 1'b1;
            wait_ready(n);
            chk("rand_rfd", 16'(n), 16'(SYNC));
        end

        // Reset while a DATA word is on the rails.
        send(8'hFF, "data_ff");
        chk("ff_literal", dout, 16'hAAAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_tok = 0;
        chk("midrst_out", dout, 16'h0000);
        chk("midrst_tok", tok_cnt, 16'd0);
        chk("midrst_ready", 16'(in_ready), 16'd0);

        wait_ready(n);
        chk("rfd_after_rst", 16'(n), 16'(SYNC));

        // Downstream never asks for NULL: watchdog fires on the TMO-th cycle.
        send(8'h0F, "data_0f");
        for (int c = 0; c < TMO - 1; c++) tick();
        chk("wd_before", 16'(err), 16'd0);
        tick();
        chk("wd_at", 16'(err), 16'(EXP_ERR));
        chk("wd_data_held", dout, enc(8'h0F));
        en = 1'b0;
        wait_null(n);
        chk("wd_rfn", 16'(n), 16'(SYNC + 1));
        chk("wd_sticky", 16'(err), 16'(EXP_ERR));
        chk("final_tok", tok_cnt, 16'(exp_tok));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
